// File: rtl/unsigned_calc_seq_ctrl.sv
// unsigned_calc_seq_ctrl: multi-cycle 7X-3Y+6Z calculator with valid/ready handshakes; CALC_CLAMP_EN clamps negative results to 0
module unsigned_calc_seq_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [3:0] i_au,
  input  logic [3:0] i_bu,
  input  logic [3:0] i_cu,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_fu,
  output logic       o_busy,
  output logic [7:0] o_cnt
);
  typedef enum logic [2:0] {IDLE, S7A, S7B, S3A, S3B, S6A, S6B, DONE} state_t;
  state_t             state_q;
  logic [3:0]         x_q, y_q, z_q;
  logic signed [9:0]  acc_q, acc_d, xe, ye, ze;
  logic [7:0]         fu_q, fu_d, cnt_q;
  logic               valid_q;
  assign xe = signed'({6'd0, x_q});
  assign ye = signed'({6'd0, y_q});
  assign ze = signed'({6'd0, z_q});
  assign acc_d = acc_q + (ze <<< 1);
`ifdef CALC_CLAMP_EN
  assign fu_d = acc_d[9] ? 8'd0 : acc_d[7:0];
`else
  assign fu_d = acc_d[7:0];
`endif
  // Operands are latched at the handshake so later input changes cannot disturb the running sum
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      acc_q   <= '0;
      fu_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else
      case (state_q)
        IDLE: if (i_valid) begin
          x_q     <= i_au;
          y_q     <= i_bu;
          z_q     <= i_cu;
          acc_q   <= '0;
          state_q <= S7A;
        end
        S7A: begin acc_q <= xe <<< 3;           state_q <= S7B; end
        S7B: begin acc_q <= acc_q - xe;         state_q <= S3A; end
        S3A: begin acc_q <= acc_q - (ye <<< 1); state_q <= S3B; end
        S3B: begin acc_q <= acc_q - ye;         state_q <= S6A; end
        S6A: begin acc_q <= acc_q + (ze <<< 2); state_q <= S6B; end
        S6B: begin
          acc_q   <= acc_d;
          fu_q    <= fu_d;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: if (i_ready) begin
          valid_q <= 1'b0;
          cnt_q   <= cnt_q + 8'd1;
          state_q <= IDLE;
        end
      endcase
  assign o_ready = state_q == IDLE;
  assign o_busy  = state_q != IDLE;
  assign o_valid = valid_q;
  assign o_fu    = fu_q;
  assign o_cnt   = cnt_q;
endmodule

// File: tb/tb_unsigned_calc_seq_ctrl.sv
// tb_unsigned_calc_seq_ctrl: directed vectors checked against a per-cycle phase/arithmetic model plus literal expectations
module tb_unsigned_calc_seq_ctrl;
  logic       clk = 0, rst = 1, i_valid = 0, i_ready = 0;
  logic [3:0] a = 0, b = 0, c = 0;
  logic       o_ready, o_valid, o_busy;
  logic [7:0] o_fu, o_cnt;
  int checks = 0, errors = 0;
  unsigned_calc_seq_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_au(a), .i_bu(b), .i_cu(c), .o_valid(o_valid), .i_ready(i_ready),
    .o_fu(o_fu), .o_busy(o_busy), .o_cnt(o_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] calc(int x, int y, int z);
    int r;
    r = 7 * x - 3 * y + 6 * z;
`ifdef CALC_CLAMP_EN
    if (r < 0) r = 0;
`endif
    return 8'(r);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  // Model: phase 0 idle, 1..6 computing, 7 result pending
  int phase = 0, m_cnt = 0;
  logic [7:0] pend = 0, m_fu = 0;
  bit m_valid = 0, armed = 0;
  always @(posedge clk)
    if (rst) begin
      phase = 0; m_valid = 0; m_fu = 0; m_cnt = 0; armed = 1;
    end else if (phase == 0) begin
      if (i_valid) begin phase = 1; pend = calc(a, b, c); end
    end else if (phase < 6) phase++;
    else if (phase == 6) begin phase = 7; m_valid = 1; m_fu = pend; end
    else if (i_ready) begin phase = 0; m_valid = 0; m_cnt = (m_cnt + 1) % 256; end
  always @(negedge clk)
    if (armed) begin
      checks++;
      if (o_ready !== (phase == 0) || o_busy !== (phase != 0) || o_valid !== m_valid ||
          o_fu !== m_fu || o_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL model rdy=%b busy=%b vld=%b fu=%h cnt=%0d expected rdy=%b busy=%b vld=%b fu=%h cnt=%0d t=%0t",
                 o_ready, o_busy, o_valid, o_fu, o_cnt, phase == 0, phase != 0, m_valid, m_fu, m_cnt, $time);
      end
    end
  task automatic run(input logic [3:0] x, y, z, input logic [7:0] exp);
    int n;
    i_valid = 1; a = x; b = y; c = z;
    @(negedge clk);
    i_valid = 0;
    a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); c = 4'($urandom_range(15));
    n = 0;
    while (!o_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", n, 6);
    chk("result", int'(o_fu), int'(exp));
  endtask
  task automatic release_result();
    i_ready = 1;
    @(negedge clk);
    i_ready = 0;
    chk("valid_drop", int'(o_valid), 0);
    chk("ready_back", int'(o_ready), 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_cnt", int'(o_cnt), 0);
    chk("rst_fu", int'(o_fu), 0);
    run(0, 0, 0, 8'h00);
    release_result();
    chk("cnt1", int'(o_cnt), 1);
    run(15, 15, 15, 8'h96);  release_result();
    run(15, 0, 15, 8'hC3);   release_result();
    run(1, 2, 4, 8'h19);     release_result();
`ifdef CALC_CLAMP_EN
    run(0, 15, 0, 8'h00);
`else
    run(0, 15, 0, 8'hD3);
`endif
    i_valid = 1; a = 4'd9; b = 4'd1; c = 4'd3;
    repeat (10) @(negedge clk);
    i_valid = 0;
    chk("hold_valid", int'(o_valid), 1);
    chk("hold_ready", int'(o_ready), 0);
`ifdef CALC_CLAMP_EN
    chk("hold_fu", int'(o_fu), 8'h00);
`else
    chk("hold_fu", int'(o_fu), 8'hD3);
`endif
    release_result();
    chk("cnt5", int'(o_cnt), 5);
    i_valid = 1; a = 4'd7; b = 4'd3; c = 4'd5;
    @(negedge clk);
    i_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ready", int'(o_ready), 1);
    chk("abort_valid", int'(o_valid), 0);
    chk("abort_fu", int'(o_fu), 0);
    chk("abort_cnt", int'(o_cnt), 0);
    run(1, 2, 4, 8'h19);
    release_result();
    chk("abort_cnt1", int'(o_cnt), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    i_valid = 1; i_ready = 1;
    for (int i = 1; i <= 2048; i++) begin
      a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); c = 4'($urandom_range(15));
      @(negedge clk);
      if (i == 2040) chk("b2b_cnt255", int'(o_cnt), 255);
    end
    chk("b2b_wrap", int'(o_cnt), 0);
    i_valid = 0; i_ready = 0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/unsigned_calc_seq_ctrl.md
UNSIGNED_CALC_SEQ_CTRL -- requirements
Module: unsigned_calc_seq_ctrl

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_valid  input  1  operand triple on i_au/i_bu/i_cu is valid.
REQ-005 o_ready  output  1  controller can accept an operand triple.
REQ-006 i_au  input  4  unsigned operand X.
REQ-007 i_bu  input  4  unsigned operand Y.
REQ-008 i_cu  input  4  unsigned operand Z.
REQ-009 o_valid  output  1  o_fu holds a completed result.
REQ-010 i_ready  input  1  consumer accepts the result.
REQ-011 o_fu  output  8  result of 7X-3Y+6Z.
REQ-012 o_busy  output  1  high in any state other than IDLE.
REQ-013 o_cnt  output  8  count of completed result handshakes, wraps 255->0.

Function
REQ-014 FSM states: IDLE, S7A, S7B, S3A, S3B, S6A, S6B, DONE; one state per clock.
REQ-015 o_ready SHALL be 1 only in IDLE; input handshake = i_valid & o_ready at a rising edge.
REQ-016 On input handshake: latch i_au/i_bu/i_cu into internal registers, clear 10-bit signed accumulator, go to S7A.
REQ-017 Micro-ops, one per state: S7A acc=X<<3; S7B acc-=X; S3A acc-=Y<<1; S3B acc-=Y; S6A acc+=Z<<2; S6B acc+=Z<<1, then DONE.
REQ-018 Accumulator SHALL be 10-bit signed; no intermediate overflow (range -45..195).
REQ-019 On entering DONE: o_fu = acc[7:0] (modulo 256), o_valid = 1; o_valid rises exactly 6 clocks after the input-handshake edge.
REQ-020 In DONE, o_fu and o_valid SHALL hold stable until i_ready is sampled high.
REQ-021 On edge with o_valid & i_ready: o_valid=0, o_cnt+=1 (wrap), go to IDLE; o_ready=1 next cycle.
REQ-022 i_valid ignored outside IDLE; operand input changes after handshake SHALL NOT affect the running computation.
REQ-023 i_ready ignored outside DONE.
REQ-024 o_fu SHALL retain last result after leaving DONE until next DONE entry.
REQ-025 Minimum throughput: one result per 8 clocks with i_valid and i_ready held high.

Reset
REQ-026 When i_rst is high at a rising edge: state=IDLE, o_valid=0, o_fu=0, o_cnt=0, accumulator and operand registers=0.
REQ-027 After reset release: o_ready=1, o_busy=0.
REQ-028 Reset in any state, including mid-computation or DONE with pending result, SHALL abort and discard; o_cnt not incremented.
REQ-029 i_rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-030 Macro CALC_CLAMP_EN: when defined, a negative final accumulator value SHALL produce o_fu=0; when undefined, o_fu = acc[7:0] (two's-complement wrap). No other behaviour differs.

Verification
REQ-031 X=0,Y=0,Z=0 -> o_fu=0x00, o_valid 6 clocks after handshake, o_cnt=1.
REQ-032 X=15,Y=15,Z=15 -> 0x96; X=15,Y=0,Z=15 -> 0xC3; X=1,Y=2,Z=4 -> 0x19.
REQ-033 X=0,Y=15,Z=0 -> 0xD3 without CALC_CLAMP_EN; 0x00 with CALC_CLAMP_EN.
REQ-034 Hold i_ready=0 for 10 clocks in DONE -> o_fu/o_valid stable, o_ready=0, new i_valid ignored; release -> IDLE next edge, o_cnt+1.
REQ-035 Assert i_rst in S3A -> next cycle IDLE, o_valid=0, o_fu=0, o_cnt=0; then X=1,Y=2,Z=4 -> 0x19.
REQ-036 256 back-to-back transactions with i_valid=i_ready=1 -> one result per 8 clocks, o_cnt wraps to 0.
